// File: rtl/arb_pkg.sv
// Shared types and helpers for the memory request arbiter.
// The FSM state encoding and the requester-index width calculation live here.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

   // Index width must never collapse to zero for a single requester.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// It scans from rr_ptr upward and wraps at NUM_REQ, which does not have to be a power of two.
module rr_picker
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int IDX_W  = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               any_valid,
   output logic [IDX_W-1:0]   winner
);

   // Scan offsets from far to near so the candidate nearest rr_ptr is the last one written.
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         int cand;
         cand = int'(rr_ptr) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end else begin
            cand = cand;
         end
         if (req_valid[cand]) begin
            any_valid = 1'b1;
            winner    = IDX_W'(cand);
         end else begin
            any_valid = any_valid;
         end
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that shares one memory port between NUM_REQ requesters.
// It keeps exactly one transaction in flight and routes each response back to the requester that issued it.
module mem_req_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*LINE_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [LINE_WIDTH-1:0]         rsp_data,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output logic [ADDR_WIDTH-1:0]         mem_req_addr,
   output logic                          mem_req_write,
   output logic [LINE_WIDTH-1:0]         mem_req_wdata,
   input  logic                          mem_rsp_valid,
   input  logic [LINE_WIDTH-1:0]         mem_rsp_data,
   output logic                          busy
);

   localparam int IDX_W = idx_width(NUM_REQ);

   arb_state_e            state_r;
   arb_state_e            state_nxt_s;
   logic [IDX_W-1:0]      rr_ptr_r;
   logic [IDX_W-1:0]      idx_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic                  write_r;
   logic [LINE_WIDTH-1:0] wdata_r;

   logic                  any_valid_s;
   logic [IDX_W-1:0]      winner_s;
   logic                  grant_s;
   logic                  rsp_fire_s;
   logic [ADDR_WIDTH-1:0] sel_addr_s;
   logic                  sel_write_s;
   logic [LINE_WIDTH-1:0] sel_wdata_s;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_r),
      .any_valid (any_valid_s),
      .winner    (winner_s)
   );

   // Select the winning requester's payload for latching.
   always_comb begin
      sel_addr_s  = '0;
      sel_write_s = 1'b0;
      sel_wdata_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner_s == IDX_W'(i)) begin
            sel_addr_s  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_write_s = req_write[i];
            sel_wdata_s = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
         end else begin
            sel_write_s = sel_write_s;
         end
      end
   end

   // Next-state logic and the combinational grant and response strobes.
   always_comb begin
      state_nxt_s   = state_r;
      req_ready     = '0;
      rsp_valid     = '0;
      rsp_data      = '0;
      mem_req_valid = 1'b0;
      busy          = 1'b0;
      grant_s       = 1'b0;
      rsp_fire_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_valid_s) begin
               grant_s     = 1'b1;
               state_nxt_s = ISSUE;
               for (int i = 0; i < NUM_REQ; i++) begin
                  req_ready[i] = (winner_s == IDX_W'(i));
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            busy          = 1'b1;
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         WAIT: begin
            busy     = 1'b1;
            rsp_data = mem_rsp_data;
            if (mem_rsp_valid) begin
               rsp_fire_s  = 1'b1;
               state_nxt_s = IDLE;
               for (int i = 0; i < NUM_REQ; i++) begin
                  rsp_valid[i] = (idx_r == IDX_W'(i));
               end
            end else begin
               state_nxt_s = WAIT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Latch the granted request and advance the round-robin pointer past the requester just served.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_r <= '0;
         idx_r    <= '0;
         addr_r   <= '0;
         write_r  <= 1'b0;
         wdata_r  <= '0;
      end else begin
         if (grant_s) begin
            idx_r   <= winner_s;
            addr_r  <= sel_addr_s;
            write_r <= sel_write_s;
            wdata_r <= sel_wdata_s;
         end else begin
            idx_r   <= idx_r;
         end
         if (rsp_fire_s) begin
            rr_ptr_r <= (idx_r == IDX_W'(NUM_REQ - 1)) ? '0 : idx_r + IDX_W'(1);
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   assign mem_req_addr  = addr_r;
   assign mem_req_write = write_r;
   assign mem_req_wdata = wdata_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter with a two-requester and a three-requester instance.
// Expected responses are queued at grant time and popped when the response is forwarded.
module tb_mem_req_arbiter;

   localparam int AW = 32;
   localparam int LW = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Two-requester instance.
   logic            reset;
   logic [1:0]      req_valid, req_write, req_ready, rsp_valid;
   logic [2*AW-1:0] req_addr;
   logic [2*LW-1:0] req_wdata;
   logic [LW-1:0]   rsp_data, mem_req_wdata, mem_rsp_data;
   logic [AW-1:0]   mem_req_addr;
   logic            mem_req_valid, mem_req_ready, mem_req_write, mem_rsp_valid, busy;

   // Three-requester instance.
   logic            reset3;
   logic [2:0]      req_valid3, req_write3, req_ready3, rsp_valid3;
   logic [3*AW-1:0] req_addr3;
   logic [3*LW-1:0] req_wdata3;
   logic [LW-1:0]   rsp_data3, mem_req_wdata3, mem_rsp_data3;
   logic [AW-1:0]   mem_req_addr3;
   logic            mem_req_valid3, mem_req_ready3, mem_req_write3, mem_rsp_valid3, busy3;

   mem_req_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) u_dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_write(mem_req_write), .mem_req_wdata(mem_req_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
   );

   mem_req_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) u_dut3 (
      .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_addr(req_addr3),
      .req_write(req_write3), .req_wdata(req_wdata3), .req_ready(req_ready3),
      .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .mem_req_valid(mem_req_valid3),
      .mem_req_ready(mem_req_ready3), .mem_req_addr(mem_req_addr3),
      .mem_req_write(mem_req_write3), .mem_req_wdata(mem_req_wdata3),
      .mem_rsp_valid(mem_rsp_valid3), .mem_rsp_data(mem_rsp_data3), .busy(busy3)
   );

   typedef struct {
      int            idx;
      logic [LW-1:0] data;
      logic          write;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total = 0;
   int   model_ptr = 0;
   int   obs_grant = -1;
   int   rsp_cnt[2];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_winner(input logic [1:0] mask);
      int w;
      w = -1;
      for (int k = 0; k < 2; k++) begin
         int c;
         c = (model_ptr + k) % 2;
         if (w < 0 && mask[c]) w = c;
      end
      return w;
   endfunction

   // One complete transaction on the two-requester instance.
   task automatic run_txn(input logic [1:0] mask, input logic [LW-1:0] data,
                          input int stalls, input int lat, input bit spur);
      int            w;
      logic [1:0]    exp_oh;
      logic [AW-1:0] a;
      logic          wr;
      logic [LW-1:0] wd;
      exp_t          e;
      req_valid = mask;
      #1;
      w = exp_winner(mask);
      exp_oh = 2'b00;
      exp_oh[w] = 1'b1;
      obs_grant = req_ready[1] ? 1 : (req_ready[0] ? 0 : -1);
      total++;
      if (req_ready !== exp_oh) $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_oh);
      else passed++;
      a  = req_addr[w*AW +: AW];
      wr = req_write[w];
      wd = req_wdata[w*LW +: LW];
      e.idx = w; e.data = data; e.write = wr;
      sb.push_back(e);
      step();
      for (int s = 0; s < stalls; s++) begin
         mem_req_ready = 1'b0;
         mem_rsp_valid = spur && (s == 0);
         mem_rsp_data  = {LW{1'b1}};
         #1;
         total++;
         if ({mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata} !== {1'b1, a, wr, wd})
            $display("FAIL issue_hold: valid=%b addr=%h wr=%b expected 1 %h %b", mem_req_valid, mem_req_addr, mem_req_write, a, wr);
         else passed++;
         total++;
         if ({rsp_valid, req_ready} !== 4'b0000)
            $display("FAIL issue_quiet: rsp_valid=%b req_ready=%b expected 00 00", rsp_valid, req_ready);
         else passed++;
         step();
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = '0;
      end
      mem_req_ready = 1'b1;
      #1;
      total++;
      if ({mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, req_ready} !== {1'b1, a, wr, wd, 2'b00})
         $display("FAIL issue_accept: valid=%b addr=%h req_ready=%b expected 1 %h 00", mem_req_valid, mem_req_addr, req_ready, a);
      else passed++;
      step();
      mem_req_ready = 1'b0;
      for (int l = 0; l < lat - 1; l++) begin
         #1;
         total++;
         if ({mem_req_valid, rsp_valid, busy} !== 4'b0001)
            $display("FAIL wait_state: mem_req_valid=%b rsp_valid=%b busy=%b expected 0 00 1", mem_req_valid, rsp_valid, busy);
         else passed++;
         step();
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = data;
      #1;
      e = sb.pop_front();
      exp_oh = 2'b00;
      exp_oh[e.idx] = 1'b1;
      if (rsp_valid[0]) rsp_cnt[0]++;
      if (rsp_valid[1]) rsp_cnt[1]++;
      total++;
      if (rsp_valid !== exp_oh) $display("FAIL rsp_route: rsp_valid=%b expected %b", rsp_valid, exp_oh);
      else passed++;
      if (!e.write) begin
         total++;
         if (rsp_data !== e.data) $display("FAIL rsp_data: got %h expected %h", rsp_data, e.data);
         else passed++;
      end
      total++;
      if (req_ready !== 2'b00) $display("FAIL grant_in_rsp: req_ready=%b expected 00", req_ready);
      else passed++;
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      model_ptr = (e.idx == 1) ? 0 : e.idx + 1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      total++;
      if ({req_ready, rsp_valid, mem_req_valid, busy, mem_req_addr, mem_req_write, mem_req_wdata, rsp_data} !== '0)
         $display("FAIL reset_outputs: ready=%b rsp=%b mvalid=%b busy=%b addr=%h expected all 0", req_ready, rsp_valid, mem_req_valid, busy, mem_req_addr);
      else passed++;
      reset = 1'b0;
      model_ptr = 0;
      step();
   endtask

   task automatic test_single_read();
      req_addr[AW +: AW] = 32'h0000_0100;
      req_write = 2'b00;
      run_txn(2'b10, 128'hDEAD, 0, 3, 1'b0);
      req_valid = 2'b00;
   endtask

   task automatic test_fairness();
      req_addr  = {32'h0000_2000, 32'h0000_1000};
      req_write = 2'b00;
      rsp_cnt[0] = 0;
      rsp_cnt[1] = 0;
      for (int t = 0; t < 4; t++) begin
         run_txn(2'b11, 128'hCAFE_0000 + LW'(t), t % 2, 1 + t, 1'b0);
         total++;
         if (obs_grant !== t % 2) $display("FAIL rr_order: txn %0d granted %0d expected %0d", t, obs_grant, t % 2);
         else passed++;
      end
      req_valid = 2'b00;
      total++;
      if (rsp_cnt[0] !== 2 || rsp_cnt[1] !== 2)
         $display("FAIL rr_counts: got %0d/%0d expected 2/2", rsp_cnt[0], rsp_cnt[1]);
      else passed++;
   endtask

   task automatic test_backpressure();
      req_addr[0 +: AW]  = 32'h0000_ABC0;
      req_write[0]       = 1'b1;
      req_wdata[0 +: LW] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      run_txn(2'b01, 128'h0, 5, 2, 1'b1);
      req_valid = 2'b00;
      req_write = 2'b00;
   endtask

   task automatic test_spurious_idle();
      req_valid     = 2'b00;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 128'h5555;
      mem_req_ready = 1'b1;
      #1;
      total++;
      if ({rsp_valid, busy, mem_req_valid, req_ready, rsp_data} !== '0)
         $display("FAIL spurious_idle: rsp=%b busy=%b mvalid=%b rsp_data=%h expected all 0", rsp_valid, busy, mem_req_valid, rsp_data);
      else passed++;
      step();
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
      #1;
      total++;
      if ({busy, mem_req_valid} !== 2'b00) $display("FAIL spurious_state: busy=%b mvalid=%b expected 0 0", busy, mem_req_valid);
      else passed++;
      run_txn(2'b01, 128'h7777, 0, 1, 1'b0);
      req_valid = 2'b00;
   endtask

   task automatic test_reset_mid();
      int         w;
      logic [1:0] exp_oh;
      req_valid = 2'b11;
      #1;
      w = exp_winner(2'b11);
      exp_oh = 2'b00;
      exp_oh[w] = 1'b1;
      total++;
      if (req_ready !== exp_oh) $display("FAIL mid_grant: req_ready=%b expected %b", req_ready, exp_oh);
      else passed++;
      step();
      req_valid     = 2'b00;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      #1;
      total++;
      if (busy !== 1'b1) $display("FAIL mid_busy: busy=%b expected 1", busy);
      else passed++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_ptr = 0;
      #1;
      total++;
      if ({req_ready, rsp_valid, mem_req_valid, busy, mem_req_addr, mem_req_write, mem_req_wdata, rsp_data} !== '0)
         $display("FAIL mid_reset: ready=%b rsp=%b mvalid=%b busy=%b addr=%h expected all 0", req_ready, rsp_valid, mem_req_valid, busy, mem_req_addr);
      else passed++;
      step();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 128'hBAD;
      #1;
      total++;
      if ({rsp_valid, busy, rsp_data} !== '0)
         $display("FAIL late_rsp: rsp=%b busy=%b rsp_data=%h expected 0", rsp_valid, busy, rsp_data);
      else passed++;
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      run_txn(2'b11, 128'h4242, 0, 1, 1'b0);
      req_valid = 2'b00;
   endtask

   task automatic test_wrap3();
      exp_t       e;
      logic [2:0] exp_oh;
      req_addr3[2*AW +: AW] = 32'h0000_0300;
      req_addr3[0 +: AW]    = 32'h0000_0040;
      req_write3            = 3'b001;
      req_wdata3[0 +: LW]   = 128'hFACE_FEED;
      reset3 = 1'b1;
      step();
      reset3 = 1'b0;
      req_valid3 = 3'b100;
      #1;
      total++;
      if (req_ready3 !== 3'b100) $display("FAIL wrap_grant2: req_ready=%b expected 100", req_ready3);
      else passed++;
      e.idx = 2; e.data = 128'h2222; e.write = 1'b0;
      sb.push_back(e);
      step();
      req_valid3     = 3'b000;
      mem_req_ready3 = 1'b1;
      #1;
      total++;
      if ({mem_req_valid3, mem_req_addr3, mem_req_write3} !== {1'b1, 32'h0000_0300, 1'b0})
         $display("FAIL wrap_issue2: valid=%b addr=%h wr=%b expected 1 00000300 0", mem_req_valid3, mem_req_addr3, mem_req_write3);
      else passed++;
      step();
      mem_req_ready3 = 1'b0;
      mem_rsp_valid3 = 1'b1;
      mem_rsp_data3  = 128'h2222;
      #1;
      e = sb.pop_front();
      exp_oh = 3'b000;
      exp_oh[e.idx] = 1'b1;
      total++;
      if ({rsp_valid3, rsp_data3} !== {exp_oh, e.data})
         $display("FAIL wrap_rsp2: rsp=%b data=%h expected %b %h", rsp_valid3, rsp_data3, exp_oh, e.data);
      else passed++;
      step();
      mem_rsp_valid3 = 1'b0;
      req_valid3 = 3'b101;
      #1;
      total++;
      if (req_ready3 !== 3'b001) $display("FAIL wrap_grant0: req_ready=%b expected 001", req_ready3);
      else passed++;
      e.idx = 0; e.data = '0; e.write = 1'b1;
      sb.push_back(e);
      step();
      req_valid3     = 3'b000;
      mem_req_ready3 = 1'b1;
      #1;
      total++;
      if ({mem_req_valid3, mem_req_addr3, mem_req_write3, mem_req_wdata3} !== {1'b1, 32'h0000_0040, 1'b1, 128'hFACE_FEED})
         $display("FAIL wrap_issue0: valid=%b addr=%h wr=%b wdata=%h", mem_req_valid3, mem_req_addr3, mem_req_write3, mem_req_wdata3);
      else passed++;
      step();
      mem_req_ready3 = 1'b0;
      mem_rsp_valid3 = 1'b1;
      #1;
      e = sb.pop_front();
      exp_oh = 3'b000;
      exp_oh[e.idx] = 1'b1;
      total++;
      if (rsp_valid3 !== exp_oh) $display("FAIL wrap_ack0: rsp=%b expected %b", rsp_valid3, exp_oh);
      else passed++;
      step();
      mem_rsp_valid3 = 1'b0;
      #1;
      total++;
      if (busy3 !== 1'b0) $display("FAIL wrap_idle: busy=%b expected 0", busy3);
      else passed++;
   endtask

   initial begin
      reset = 1'b1;         reset3 = 1'b1;
      req_valid = '0;       req_valid3 = '0;
      req_addr = '0;        req_addr3 = '0;
      req_write = '0;       req_write3 = '0;
      req_wdata = '0;       req_wdata3 = '0;
      mem_req_ready = 1'b0; mem_req_ready3 = 1'b0;
      mem_rsp_valid = 1'b0; mem_rsp_valid3 = 1'b0;
      mem_rsp_data = '0;    mem_rsp_data3 = '0;
      test_reset();
      test_single_read();
      test_fairness();
      test_backpressure();
      test_spurious_idle();
      test_reset_mid();
      test_wrap3();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
